// File: rtl/spi_reg_bank.sv
// SPI-side register bank: writable registers, a self-clearing instruction register and a serial readback engine.
// Optional odd-parity bit after each readback frame is enabled by defining SPI_REG_PARITY_EN.
module spi_reg_bank #(
  parameter int                  NUM_REGS   = 8,
  parameter int                  DATA_W     = 8,
  parameter int                  ADDR_W     = 7,
  parameter int                  INSTR_ADDR = 3,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                       spi_clk,
  input  logic                       rstn,
  input  logic                       csb,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       is_write,
  input  logic                       addr_valid,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wdata_valid,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_ack,
  output logic                       addr_err,
  output logic                       poci_spi
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SPI_REG_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TAIL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  logic [31:0]         addr_ext;
  logic [NUM_REGS-1:0] hit_vec;
  logic [NUM_REGS-1:0] wr_sel_reg;
  logic [NUM_REGS-1:0] commit_vec;
  logic                wr_bad_reg;
  logic                wr_commit;
  logic                wr_err;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_hit;

  state_t              state_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                rd_err_reg;
`ifdef SPI_REG_PARITY_EN
  logic                parity_reg;
`endif

  assign addr_ext = 32'(addr);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] value_reg;

      assign hit_vec[gi] = (addr_ext == 32'(gi + 1));

      if (gi + 1 == INSTR_ADDR) begin : g_instr
        // Instruction register only holds its value while the chip is selected.
        always_ff @(posedge spi_clk or negedge rstn or posedge csb) begin
          if (!rstn) begin
            value_reg <= '0;
          end else if (csb) begin
            value_reg <= '0;
          end else if (commit_vec[gi]) begin
            value_reg <= wdata;
          end
        end
      end else begin : g_plain
        always_ff @(posedge spi_clk or negedge rstn) begin
          if (!rstn) begin
            value_reg <= '0;
          end else if (commit_vec[gi]) begin
            value_reg <= wdata;
          end
        end
      end

      assign regs_flat[gi*DATA_W +: DATA_W] = value_reg;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hit_vec[i]) begin
        rd_data = regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_hit = |hit_vec;

  // A write is armed by its addr_valid and disarmed by csb or reset, so a
  // transaction interrupted by reset can never complete a write afterwards.
  always_ff @(posedge spi_clk or negedge rstn or posedge csb) begin
    if (!rstn) begin
      wr_sel_reg <= '0;
      wr_bad_reg <= 1'b0;
    end else if (csb) begin
      wr_sel_reg <= '0;
      wr_bad_reg <= 1'b0;
    end else if (addr_valid) begin
      wr_sel_reg <= is_write ? (hit_vec & ~RO_MASK) : '0;
      wr_bad_reg <= is_write & ~(|(hit_vec & ~RO_MASK));
    end
  end

  assign commit_vec = wdata_valid ? wr_sel_reg : '0;
  assign wr_commit  = |commit_vec;
  assign wr_err     = wdata_valid & wr_bad_reg;

  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ack   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      wr_ack   <= wr_commit;
      addr_err <= addr_err | wr_err | rd_err_reg;
    end
  end

  // Readback engine; a new read addr_valid always reloads, even mid-frame.
  always_ff @(posedge spi_clk or negedge rstn or posedge csb) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      rd_err_reg <= 1'b0;
`ifdef SPI_REG_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else if (csb) begin
      state_reg  <= S_IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      rd_err_reg <= 1'b0;
`ifdef SPI_REG_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else if (addr_valid && !is_write) begin
      state_reg  <= S_SHIFT;
      shift_reg  <= rd_data;
      cnt_reg    <= '0;
      rd_err_reg <= ~rd_hit;
`ifdef SPI_REG_PARITY_EN
      parity_reg <= ~^rd_data;
`endif
    end else begin
      rd_err_reg <= 1'b0;
      case (state_reg)
        S_SHIFT: begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
`ifdef SPI_REG_PARITY_EN
            state_reg <= S_TAIL;
`else
            state_reg <= S_IDLE;
`endif
          end
        end
`ifdef SPI_REG_PARITY_EN
        S_TAIL: begin
          state_reg <= S_IDLE;
        end
`endif
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    poci_spi = 1'b0;
    if (state_reg == S_SHIFT) begin
      poci_spi = shift_reg[DATA_W-1];
    end
`ifdef SPI_REG_PARITY_EN
    if (state_reg == S_TAIL) begin
      poci_spi = parity_reg;
    end
`endif
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed cases plus random transactions checked by a queue-based scoreboard.
module tb_spi_reg_bank;
  localparam int NR = 8;
  localparam int DW = 8;
  localparam int AW = 7;
`ifdef SPI_REG_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic              spi_clk = 1'b0;
  logic              rstn = 1'b0;
  logic              csb = 1'b1;
  logic [AW-1:0]     addr = '0;
  logic              is_write = 1'b0;
  logic              addr_valid = 1'b0;
  logic [DW-1:0]     wdata = '0;
  logic              wdata_valid = 1'b0;
  logic [NR*DW-1:0]  regs_flat;
  logic              wr_ack;
  logic              addr_err;
  logic              poci_spi;

  spi_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .INSTR_ADDR(3), .RO_MASK(8'h01)) dut (
    .spi_clk(spi_clk), .rstn(rstn), .csb(csb), .addr(addr), .is_write(is_write),
    .addr_valid(addr_valid), .wdata(wdata), .wdata_valid(wdata_valid),
    .regs_flat(regs_flat), .wr_ack(wr_ack), .addr_err(addr_err), .poci_spi(poci_spi)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct { logic ack; logic [NR*DW-1:0] flat; logic err; } wr_item_t;
  typedef struct { logic [15:0] bits; int len; logic err; } rd_item_t;

  wr_item_t wr_q[$];
  rd_item_t rd_q[$];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: register contents by address plus the sticky error flag.
  logic [DW-1:0] mdl [1:NR];
  logic          mdl_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 1; i <= NR; i++) f[(i-1)*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic logic valid_addr(input int a);
    return (a >= 1) && (a <= NR);
  endfunction

  function automatic rd_item_t make_rd(input int a);
    rd_item_t it;
    logic [DW-1:0] v;
    v = valid_addr(a) ? mdl[a] : '0;
    if (!valid_addr(a)) mdl_err = 1'b1;
    it.err = mdl_err;
`ifdef SPI_REG_PARITY_EN
    it.bits = {7'b0, v, ~(^v)};
`else
    it.bits = {8'b0, v};
`endif
    it.len = FL;
    return it;
  endfunction

  function automatic wr_item_t make_wr(input int a, input logic [DW-1:0] d);
    wr_item_t it;
    if (valid_addr(a) && a != 1) begin
      mdl[a] = d;
      it.ack = 1'b1;
    end else begin
      mdl_err = 1'b1;
      it.ack = 1'b0;
    end
    it.flat = model_flat();
    it.err = mdl_err;
    return it;
  endfunction

  // Snapshot of what the bench presented at each rising edge.
  logic s_wv = 1'b0, s_av = 1'b0, s_wr = 1'b0;
  always @(posedge spi_clk) begin
    s_wv <= wdata_valid & ~csb & rstn;
    s_av <= addr_valid & ~csb & rstn;
    s_wr <= is_write;
  end

  rd_item_t cur;
  bit       active = 1'b0;
  int       idx = 0;

  always @(negedge spi_clk) begin
    wr_item_t w;
    if (!rstn || csb) begin
      active = 1'b0;
      chk("poci_deselected", poci_spi, 1'b0);
    end else begin
      if (s_av && !s_wr) begin
        if (rd_q.size() == 0) chk("rd_queue_nonempty", 0, 1);
        else begin
          cur = rd_q.pop_front();
          idx = 0;
          active = 1'b1;
        end
      end
      if (active) begin
        if (idx < cur.len) begin
          chk("poci_bit", poci_spi, cur.bits[cur.len-1-idx]);
          idx++;
        end else begin
          chk("poci_frame_end", poci_spi, 1'b0);
          chk("rd_addr_err", addr_err, cur.err);
          active = 1'b0;
        end
      end else begin
        chk("poci_idle", poci_spi, 1'b0);
      end
    end
    if (rstn) begin
      if (s_wv) begin
        if (wr_q.size() == 0) chk("wr_queue_nonempty", 0, 1);
        else begin
          w = wr_q.pop_front();
          chk("wr_ack", wr_ack, w.ack);
          chk("regs_flat_wr", regs_flat, w.flat);
          chk("wr_addr_err", addr_err, w.err);
        end
      end else begin
        chk("wr_ack_quiet", wr_ack, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic deselect();
    csb = 1'b1;
    mdl[3] = '0;
    #1;
    chk("regs_after_csb", regs_flat, model_flat());
    tick();
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    csb = 1'b0; addr = AW'(a); is_write = 1'b1; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    wr_q.push_back(make_wr(a, d));
    wdata = d; wdata_valid = 1'b1;
    tick();
    wdata_valid = 1'b0;
    tick();
    deselect();
  endtask

  task automatic do_read(input int a);
    csb = 1'b0; addr = AW'(a); is_write = 1'b0; addr_valid = 1'b1;
    rd_q.push_back(make_rd(a));
    tick();
    addr_valid = 1'b0;
    repeat (FL + 1) tick();
    deselect();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 1; i <= NR; i++) mdl[i] = '0;
    mdl_err = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    int a;
    for (int i = 1; i <= NR; i++) mdl[i] = '0;
    mdl_err = 1'b0;
    tick();
    chk("reset_regs", regs_flat, '0);
    chk("reset_wr_ack", wr_ack, 1'b0);
    chk("reset_addr_err", addr_err, 1'b0);
    chk("reset_poci", poci_spi, 1'b0);
    rstn = 1'b1;
    tick();

    do_write(2, 8'hA5);
    do_write(3, 8'h3C);
    chk("instr_cleared", regs_flat[23:16], 8'h00);
    chk("addr2_kept", regs_flat[15:8], 8'hA5);
    do_read(2);
    do_write(5, 8'h11);

    // Write to addr 5 and read of addr 5 on the same edge: read sees the old value.
    csb = 1'b0; addr = 7'd5; is_write = 1'b1; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    tick();
    rd_q.push_back(make_rd(5));
    wr_q.push_back(make_wr(5, 8'h9E));
    wdata = 8'h9E; wdata_valid = 1'b1; addr_valid = 1'b1; is_write = 1'b0;
    tick();
    wdata_valid = 1'b0; addr_valid = 1'b0;
    repeat (FL + 1) tick();
    deselect();

    // Restart: a second read addr_valid mid-frame takes over.
    do_write(4, 8'h6B);
    csb = 1'b0; addr = 7'd2; is_write = 1'b0; addr_valid = 1'b1;
    rd_q.push_back(make_rd(2));
    tick();
    addr_valid = 1'b0;
    repeat (3) tick();
    addr = 7'd4; addr_valid = 1'b1;
    rd_q.push_back(make_rd(4));
    tick();
    addr_valid = 1'b0;
    repeat (FL + 1) tick();
    deselect();

    // Abort: csb rises while bit 4 is on the line.
    csb = 1'b0; addr = 7'd2; is_write = 1'b0; addr_valid = 1'b1;
    rd_q.push_back(make_rd(2));
    tick();
    addr_valid = 1'b0;
    repeat (4) tick();
    csb = 1'b1;
    #1;
    chk("poci_abort", poci_spi, 1'b0);
    tick();
    tick();
    chk("no_err_yet", addr_err, 1'b0);

    do_write(0, 8'hFF);
    do_write(9, 8'hFF);
    chk("err_sticky", addr_err, 1'b1);
    do_write(1, 8'h55);
    chk("ro_addr1", regs_flat[7:0], 8'h00);
    do_read(10);
    repeat (5) tick();
    chk("err_still_set", addr_err, 1'b1);

    // Reset in the middle of an armed write: the later wdata_valid must not commit.
    csb = 1'b0; addr = 7'd6; is_write = 1'b1; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    do_reset();
    chk("err_cleared_by_reset", addr_err, 1'b0);
    wr_q.push_back('{ack: 1'b0, flat: model_flat(), err: 1'b0});
    wdata = 8'h77; wdata_valid = 1'b1;
    tick();
    wdata_valid = 1'b0;
    tick();
    deselect();

    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 10);
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a);
    end

    repeat (3) tick();
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("final_regs", regs_flat, model_flat());
    chk("final_err", addr_err, mdl_err);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
